alarm_set_bank: RTL and testbench

Parametrised multi-slot alarm store for the alarm clock. It holds N_SLOTS independent alarm settings (day, hour, minute, on/off) and edits the selected slot with synchronous load, increment, toggle and clear commands. Every enabled slot is compared against the running time, producing per-slot match flags and a single-cycle alarm pulse. It sits between the current-time counters (CTI source) and the alarm output/display path (STO consumer), and generalises the single-setting set-time logic to many slots, optional minute-to-hour carry and a "daily" day code.

---
 rtl/alarm_set_bank.sv | 194 +++++++++++++++++++
 tb/tb_alarm_set_bank.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_set_bank.sv
// Multi-slot alarm setting store: edits the selected slot and compares every
// enabled slot against the running time, raising a one-cycle pulse on new matches.
module alarm_set_bank #(
  parameter int unsigned N_SLOTS   = 7,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned MIN_CARRY = 0
) (
  input  logic               clk_i,
  input  logic               clear_n_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [14:0]        cti_i,
  input  logic               ld_time_i,
  input  logic               ld_day_i,
  input  logic               im_i,
  input  logic               ih_i,
  input  logic               id_i,
  input  logic               tog_i,
  input  logic               clr_sel_i,
  output logic [15:0]        sto_o,
  output logic [N_SLOTS-1:0] match_o,
  output logic               alarm_o
);

  localparam logic       CARRY_EN  = (MIN_CARRY != 0);
  localparam logic [2:0] DAY_DAILY = 3'd7;

  logic       on_q   [N_SLOTS];
  logic       on_d   [N_SLOTS];
  logic [2:0] day_q  [N_SLOTS];
  logic [2:0] day_d  [N_SLOTS];
  logic [4:0] hour_q [N_SLOTS];
  logic [4:0] hour_d [N_SLOTS];
  logic [2:0] mt_q   [N_SLOTS];
  logic [2:0] mt_d   [N_SLOTS];
  logic [3:0] mo_q   [N_SLOTS];
  logic [3:0] mo_d   [N_SLOTS];

  logic [N_SLOTS-1:0] match_c;
  logic [N_SLOTS-1:0] match_q;
  logic               alarm_q;

  logic [2:0] cti_day;
  logic [4:0] cti_hour;
  logic [2:0] cti_mt;
  logic [3:0] cti_mo;

  assign cti_day  = cti_i[14:12];
  assign cti_hour = cti_i[11:7];
  assign cti_mt   = cti_i[6:4];
  assign cti_mo   = cti_i[3:0];

  // Range-sanitised load values: an out-of-range field loads as zero.
  logic [2:0] ld_day_c;
  logic [4:0] ld_hour_c;
  logic [2:0] ld_mt_c;
  logic [3:0] ld_mo_c;

  assign ld_day_c  = (cti_day == DAY_DAILY) ? 3'd0 : cti_day;
  assign ld_hour_c = (cti_hour > 5'd23) ? 5'd0 : cti_hour;
  assign ld_mt_c   = (cti_mt > 3'd5) ? 3'd0 : cti_mt;
  assign ld_mo_c   = (cti_mo > 4'd9) ? 4'd0 : cti_mo;

  // Selected-slot readout; an unmapped SEL selects nothing and reads as zero.
  logic       rd_on_c;
  logic [2:0] rd_day_c;
  logic [4:0] rd_hour_c;
  logic [2:0] rd_mt_c;
  logic [3:0] rd_mo_c;

  always_comb begin
    rd_on_c   = 1'b0;
    rd_day_c  = 3'd0;
    rd_hour_c = 5'd0;
    rd_mt_c   = 3'd0;
    rd_mo_c   = 4'd0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (32'(sel_i) == i) begin
        rd_on_c   = on_q[i];
        rd_day_c  = day_q[i];
        rd_hour_c = hour_q[i];
        rd_mt_c   = mt_q[i];
        rd_mo_c   = mo_q[i];
      end
    end
  end

  assign sto_o = {rd_on_c, rd_day_c, rd_hour_c, rd_mt_c, rd_mo_c};

  // Increment path for the selected slot; the hour may step by 0, 1 or 2.
  logic       min_wrap_c;
  logic [2:0] inc_mt_c;
  logic [3:0] inc_mo_c;
  logic [1:0] hour_step_c;
  logic [5:0] hour_sum_c;
  logic [4:0] inc_hour_c;
  logic [2:0] inc_day_c;

  always_comb begin
    min_wrap_c = 1'b0;
    inc_mt_c   = rd_mt_c;
    inc_mo_c   = rd_mo_c;
    if (im_i) begin
      if (rd_mo_c == 4'd9) begin
        inc_mo_c = 4'd0;
        if (rd_mt_c == 3'd5) begin
          inc_mt_c   = 3'd0;
          min_wrap_c = 1'b1;
        end else begin
          inc_mt_c = rd_mt_c + 3'd1;
        end
      end else begin
        inc_mo_c = rd_mo_c + 4'd1;
      end
    end
    hour_step_c = {1'b0, ih_i} + {1'b0, min_wrap_c & CARRY_EN};
    hour_sum_c  = 6'(rd_hour_c) + 6'(hour_step_c);
    inc_hour_c  = (hour_sum_c >= 6'd24) ? 5'(hour_sum_c - 6'd24) : 5'(hour_sum_c);
    inc_day_c   = id_i ? (rd_day_c + 3'd1) : rd_day_c;
  end

  // Command priority: clear, then loads, then toggle, then increments.
  always_comb begin
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      on_d[i]   = on_q[i];
      day_d[i]  = day_q[i];
      hour_d[i] = hour_q[i];
      mt_d[i]   = mt_q[i];
      mo_d[i]   = mo_q[i];
      if (32'(sel_i) == i) begin
        if (clr_sel_i) begin
          on_d[i]   = 1'b0;
          day_d[i]  = 3'd0;
          hour_d[i] = 5'd0;
          mt_d[i]   = 3'd0;
          mo_d[i]   = 4'd0;
        end else if (ld_time_i || ld_day_i) begin
          if (ld_time_i) begin
            hour_d[i] = ld_hour_c;
            mt_d[i]   = ld_mt_c;
            mo_d[i]   = ld_mo_c;
          end
          if (ld_day_i) begin
            day_d[i] = ld_day_c;
          end
        end else if (tog_i) begin
          on_d[i] = ~on_q[i];
        end else begin
          day_d[i]  = inc_day_c;
          hour_d[i] = inc_hour_c;
          mt_d[i]   = inc_mt_c;
          mo_d[i]   = inc_mo_c;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      match_c[i] = on_q[i] &&
                   ((day_q[i] == cti_day) || (day_q[i] == DAY_DAILY)) &&
                   (hour_q[i] == cti_hour) &&
                   (mt_q[i] == cti_mt) &&
                   (mo_q[i] == cti_mo);
    end
  end

  always_ff @(posedge clk_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        on_q[i]   <= 1'b0;
        day_q[i]  <= 3'd0;
        hour_q[i] <= 5'd0;
        mt_q[i]   <= 3'd0;
        mo_q[i]   <= 4'd0;
      end
      match_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        on_q[i]   <= on_d[i];
        day_q[i]  <= day_d[i];
        hour_q[i] <= hour_d[i];
        mt_q[i]   <= mt_d[i];
        mo_q[i]   <= mo_d[i];
      end
      match_q <= match_c;
      alarm_q <= |(match_c & ~match_q);
    end
  end

  assign match_o = match_q;
  assign alarm_o = alarm_q;

endmodule

// File: tb/tb_alarm_set_bank.sv
// Bench for alarm_set_bank: two instances (minute carry off/on) driven together
// and checked against a minute-count reference model.
module tb_alarm_set_bank;

  localparam int NS = 7;

  logic          clk = 1'b0;
  logic          clear_n;
  logic [2:0]    sel;
  logic [14:0]   cti;
  logic          ld_time, ld_day, im, ih, id, tog, clr_sel;
  logic [15:0]   sto0, sto1;
  logic [NS-1:0] match0, match1;
  logic          alarm0, alarm1;

  always #5 clk = ~clk;

  alarm_set_bank #(.N_SLOTS(NS), .SEL_W(3), .MIN_CARRY(0)) u_dut0 (
    .clk_i(clk), .clear_n_i(clear_n), .sel_i(sel), .cti_i(cti),
    .ld_time_i(ld_time), .ld_day_i(ld_day), .im_i(im), .ih_i(ih), .id_i(id),
    .tog_i(tog), .clr_sel_i(clr_sel),
    .sto_o(sto0), .match_o(match0), .alarm_o(alarm0)
  );

  alarm_set_bank #(.N_SLOTS(NS), .SEL_W(3), .MIN_CARRY(1)) u_dut1 (
    .clk_i(clk), .clear_n_i(clear_n), .sel_i(sel), .cti_i(cti),
    .ld_time_i(ld_time), .ld_day_i(ld_day), .im_i(im), .ih_i(ih), .id_i(id),
    .tog_i(tog), .clr_sel_i(clr_sel),
    .sto_o(sto1), .match_o(match1), .alarm_o(alarm1)
  );

  int vectors;
  int miscompares;

  // Reference model: index 0 = no carry, 1 = carry; minute kept as 0..59.
  int            m_on   [2][NS];
  int            m_day  [2][NS];
  int            m_hour [2][NS];
  int            m_min  [2][NS];
  logic [NS-1:0] m_match [2];
  logic          m_alarm [2];

  function automatic logic [14:0] cti_of(int d, int h, int m);
    return {3'(d), 5'(h), 3'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] exp_sto(int k, int s);
    if (s >= NS) return 16'h0000;
    return {1'(m_on[k][s]), 3'(m_day[k][s]), 5'(m_hour[k][s]),
            3'(m_min[k][s] / 10), 4'(m_min[k][s] % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NS; i++) begin
        m_on[k][i] = 0; m_day[k][i] = 0; m_hour[k][i] = 0; m_min[k][i] = 0;
      end
      m_match[k] = '0;
      m_alarm[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [NS-1:0] now;
    int cd, ch, cmt, cmo, s, wrap;
    cd  = int'(cti[14:12]);
    ch  = int'(cti[11:7]);
    cmt = int'(cti[6:4]);
    cmo = int'(cti[3:0]);
    s   = int'(sel);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NS; i++) begin
        now[i] = (m_on[k][i] != 0) && (m_day[k][i] == cd || m_day[k][i] == 7) &&
                 (m_hour[k][i] == ch) && (m_min[k][i] / 10 == cmt) &&
                 (m_min[k][i] % 10 == cmo);
      end
      m_alarm[k] = |(now & ~m_match[k]);
      m_match[k] = now;
      if (s < NS) begin
        if (clr_sel) begin
          m_on[k][s] = 0; m_day[k][s] = 0; m_hour[k][s] = 0; m_min[k][s] = 0;
        end else if (ld_time || ld_day) begin
          if (ld_time) begin
            m_hour[k][s] = (ch > 23) ? 0 : ch;
            m_min[k][s]  = ((cmt > 5) ? 0 : cmt) * 10 + ((cmo > 9) ? 0 : cmo);
          end
          if (ld_day) m_day[k][s] = (cd == 7) ? 0 : cd;
        end else if (tog) begin
          m_on[k][s] = 1 - m_on[k][s];
        end else begin
          wrap = 0;
          if (im) begin
            m_min[k][s] = m_min[k][s] + 1;
            if (m_min[k][s] == 60) begin
              m_min[k][s] = 0;
              wrap = 1;
            end
          end
          m_hour[k][s] = (m_hour[k][s] + int'(ih) + ((k == 1) ? wrap : 0)) % 24;
          if (id) m_day[k][s] = (m_day[k][s] + 1) % 8;
        end
      end
    end
  endtask

  // One clock: model follows the DUT edge, commands drop back to idle at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    ld_time = 0; ld_day = 0; im = 0; ih = 0; id = 0; tog = 0; clr_sel = 0;
  endtask

  task automatic test_reset();
    clear_n = 0; sel = 0; cti = 0;
    ld_time = 0; ld_day = 0; im = 0; ih = 0; id = 0; tog = 0; clr_sel = 0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      vectors++;
      if (sto0 !== 16'h0000 || sto1 !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_sto sel=%0d got %h/%h want 0000", s, sto0, sto1);
      end
    end
    vectors++;
    if (match0 !== '0 || match1 !== '0 || alarm0 !== 1'b0 || alarm1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs match=%b/%b alarm=%b/%b want 0", match0, match1, alarm0, alarm1);
    end
    @(negedge clk);
    clear_n = 1; sel = 0;
  endtask

  task automatic test_program();
    sel = 2; cti = cti_of(3, 7, 45);
    ld_time = 1; ld_day = 1; step();
    tog = 1; step();
    vectors++;
    if (sto0 !== 16'hB3C5 || sto1 !== 16'hB3C5) begin
      miscompares++;
      $display("FAIL program_sto got %h/%h want b3c5", sto0, sto1);
    end
    vectors++;
    if (match0[2] !== 1'b0 || alarm0 !== 1'b0) begin
      miscompares++;
      $display("FAIL program_latency match2=%b alarm=%b want 0/0", match0[2], alarm0);
    end
    step();
    vectors++;
    if (match0[2] !== 1'b1 || alarm0 !== 1'b1 || match1[2] !== 1'b1 || alarm1 !== 1'b1) begin
      miscompares++;
      $display("FAIL program_match match2=%b/%b alarm=%b/%b want 1/1", match0[2], match1[2], alarm0, alarm1);
    end
    step();
    vectors++;
    if (match0[2] !== 1'b1 || alarm0 !== 1'b0 || alarm1 !== 1'b0) begin
      miscompares++;
      $display("FAIL program_no_repeat match2=%b alarm=%b/%b want 1/0", match0[2], alarm0, alarm1);
    end
  endtask

  task automatic test_carry();
    sel = 3; cti = cti_of(0, 23, 59);
    ld_time = 1; step();
    im = 1; ih = 1; step();
    vectors++;
    if (sto0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL carry_off got %h want 0000", sto0);
    end
    vectors++;
    if (sto1 !== 16'h0080) begin
      miscompares++;
      $display("FAIL carry_on got %h want 0080", sto1);
    end
  endtask

  task automatic test_daily();
    sel = 4;
    repeat (7) begin id = 1; step(); end
    vectors++;
    if (sto0 !== 16'h7000 || sto1 !== 16'h7000) begin
      miscompares++;
      $display("FAIL daily_code got %h/%h want 7000", sto0, sto1);
    end
    tog = 1; step();
    cti = cti_of(0, 6, 30); ld_time = 1; step();
    for (int d = 0; d < 7; d++) begin
      cti = cti_of(d, 6, 30);
      step();
      vectors++;
      if (match0[4] !== 1'b1 || match1[4] !== 1'b1 || alarm0 !== 1'(d == 0)) begin
        miscompares++;
        $display("FAIL daily_day%0d match4=%b/%b alarm=%b want 1/1/%0d", d, match0[4], match1[4], alarm0, d == 0);
      end
    end
    cti = cti_of(2, 12, 0); step();
    vectors++;
    if (match0[4] !== 1'b0 || match1[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL daily_drop match4=%b/%b want 0", match0[4], match1[4]);
    end
  endtask

  task automatic test_boundary();
    sel = 5; cti = {3'd1, 5'd25, 3'd6, 4'd3};
    ld_time = 1; step();
    vectors++;
    if (sto0 !== 16'h0003 || sto1 !== 16'h0003) begin
      miscompares++;
      $display("FAIL range_load got %h/%h want 0003", sto0, sto1);
    end
    cti = cti_of(1, 10, 10);
    clr_sel = 1; ld_time = 1; tog = 1; step();
    vectors++;
    if (sto0 !== 16'h0000 || sto1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL clear_priority got %h/%h want 0000", sto0, sto1);
    end
    sel = 3'(NS); tog = 1; step();
    vectors++;
    if (sto0 !== 16'h0000 || sto1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL bad_sel_sto got %h/%h want 0000", sto0, sto1);
    end
    for (int s = 0; s < NS; s++) begin
      sel = 3'(s);
      #1;
      vectors++;
      if (sto0 !== exp_sto(0, s) || sto1 !== exp_sto(1, s)) begin
        miscompares++;
        $display("FAIL bad_sel_slots slot=%0d got %h/%h want %h/%h", s, sto0, sto1, exp_sto(0, s), exp_sto(1, s));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    cti = cti_of(2, 9, 15);
    for (int s = 0; s < 2; s++) begin
      sel = 3'(s); ld_time = 1; ld_day = 1; step();
    end
    cti = cti_of(2, 9, 14);
    for (int s = 0; s < 2; s++) begin
      sel = 3'(s); tog = 1; step();
    end
    step();
    cti = cti_of(2, 9, 15); step();
    vectors++;
    if (match0[1:0] !== 2'b11 || match1[1:0] !== 2'b11 || alarm0 !== 1'b1 || alarm1 !== 1'b1) begin
      miscompares++;
      $display("FAIL dual_match match=%b/%b alarm=%b/%b want 11/1", match0, match1, alarm0, alarm1);
    end
    step();
    vectors++;
    if (match0[1:0] !== 2'b11 || alarm0 !== 1'b0 || alarm1 !== 1'b0) begin
      miscompares++;
      $display("FAIL dual_single_pulse match=%b alarm=%b/%b want 11/0", match0, alarm0, alarm1);
    end
    @(posedge clk);
    model_edge();
    #2 clear_n = 0;
    #1;
    vectors++;
    if (match0 !== '0 || match1 !== '0 || alarm0 !== 1'b0 || alarm1 !== 1'b0 || sto0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_reset match=%b/%b alarm=%b/%b sto=%h want 0", match0, match1, alarm0, alarm1, sto0);
    end
    model_reset();
    @(negedge clk);
    clear_n = 1;
    repeat (3) begin
      step();
      vectors++;
      if (match0 !== '0 || match1 !== '0 || alarm0 !== 1'b0 || alarm1 !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet match=%b/%b alarm=%b/%b want 0", match0, match1, alarm0, alarm1);
      end
    end
  endtask

  task automatic test_random();
    int s;
    for (int n = 0; n < 400; n++) begin
      sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        s = int'($urandom_range(0, NS - 1));
        cti = cti_of(int'($urandom_range(0, 7)), m_hour[0][s], m_min[0][s]);
      end else begin
        cti = 15'($urandom);
      end
      clr_sel = ($urandom_range(0, 15) == 0);
      ld_time = ($urandom_range(0, 7) == 0);
      ld_day  = ($urandom_range(0, 7) == 0);
      tog     = ($urandom_range(0, 3) == 0);
      im      = ($urandom_range(0, 1) == 0);
      ih      = ($urandom_range(0, 2) == 0);
      id      = ($urandom_range(0, 2) == 0);
      step();
      vectors++;
      if (sto0 !== exp_sto(0, int'(sel)) || sto1 !== exp_sto(1, int'(sel))) begin
        miscompares++;
        $display("FAIL rand_sto n=%0d sel=%0d got %h/%h want %h/%h", n, sel, sto0, sto1,
                 exp_sto(0, int'(sel)), exp_sto(1, int'(sel)));
      end
      vectors++;
      if (match0 !== m_match[0] || match1 !== m_match[1] ||
          alarm0 !== m_alarm[0] || alarm1 !== m_alarm[1]) begin
        miscompares++;
        $display("FAIL rand_match n=%0d got %b/%b alarm %b/%b want %b/%b alarm %b/%b", n,
                 match0, match1, alarm0, alarm1, m_match[0], m_match[1], m_alarm[0], m_alarm[1]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_program();
    test_carry();
    test_daily();
    test_boundary();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
